// File: rtl/mem_write_arbiter.sv
// Two-requester write sequencer for the latch-based word memory.
// Each write runs setup -> store pulse -> hold so latch timing stays clean.
module mem_write_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 2,
  parameter int STORE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = $clog2(STORE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STORE,
    HOLD,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gid_q, gid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              store_q, store_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last time wins
          pick    = (req0 && req1) ? ~last_q : req1;
          gid_d   = pick;
          addr_d  = pick ? addr1 : addr0;
          data_d  = pick ? data1 : data0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(STORE_CYCLES - 1);
        state_d = STORE;
      end
      STORE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        state_d = DONE;
      end
      DONE: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Strobes are registered off the current state, so they lag it by one
    store_d = (state_q == STORE);
    ack0_d  = (state_q == DONE) && !gid_q;
    ack1_d  = (state_q == DONE) && gid_q;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      store_q <= store_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign mem_store = store_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: STORE_CYCLES=2 and =1 builds side by side,
// checked against a transaction-timing model.
module tb_mem_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;

  logic       a_ack0, a_ack1, a_store, a_busy, a_gid;
  logic [1:0] a_addr;
  logic [7:0] a_data;
  logic       b_ack0, b_ack1, b_store, b_busy, b_gid;
  logic [1:0] b_addr;
  logic [7:0] b_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_write_arbiter #(.DATA_W(8), .ADDR_W(2), .STORE_CYCLES(2)) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(a_ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(a_ack1),
    .mem_addr(a_addr), .mem_data(a_data), .mem_store(a_store),
    .busy(a_busy), .grant_id(a_gid)
  );

  mem_write_arbiter #(.DATA_W(8), .ADDR_W(2), .STORE_CYCLES(1)) u_b (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(b_ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(b_ack1),
    .mem_addr(b_addr), .mem_data(b_data), .mem_store(b_store),
    .busy(b_busy), .grant_id(b_gid)
  );

  // Model: per build, a transaction started at edge st by requester who.
  int         edge_n = 0;
  bit         act [2] = '{0, 0};
  int         st  [2];
  bit         who [2];
  bit         last[2] = '{1, 1};
  logic [1:0] ex_addr [2];
  logic [7:0] ex_data [2];
  logic       ex_gid  [2];
  logic       ex_busy [2];
  logic       ex_store[2];
  logic       ex_ack0 [2];
  logic       ex_ack1 [2];
  logic [7:0] ex_mem  [2][4];
  logic [7:0] ob_mem  [2][4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int sc, k;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      sc = (i == 0) ? 2 : 1;
      ex_ack0[i] = 1'b0;
      ex_ack1[i] = 1'b0;
      if (reset) begin
        act[i]     = 1'b0;
        last[i]    = 1'b1;
        ex_addr[i] = '0;
        ex_data[i] = '0;
        ex_gid[i]  = 1'b0;
      end else if (act[i] && (edge_n - st[i] == sc + 3)) begin
        if (who[i]) ex_ack1[i] = 1'b1;
        else        ex_ack0[i] = 1'b1;
        last[i] = who[i];
        act[i]  = 1'b0;
      end else if (!act[i] && (req0 || req1)) begin
        who[i]     = (req0 && req1) ? !last[i] : req1;
        act[i]     = 1'b1;
        st[i]      = edge_n;
        ex_addr[i] = who[i] ? addr1 : addr0;
        ex_data[i] = who[i] ? data1 : data0;
        ex_gid[i]  = who[i];
      end
      k = edge_n - st[i];
      ex_busy[i]  = act[i];
      ex_store[i] = act[i] && (k >= 2) && (k <= sc + 1);
      if (ex_store[i]) ex_mem[i][ex_addr[i]] = ex_data[i];
    end
  endtask

  task automatic chk_inst(input int i, input logic ack0_o,
                          input logic ack1_o, input logic store_o,
                          input logic busy_o, input logic gid_o,
                          input logic [1:0] addr_o, input logic [7:0] data_o);
    string p;
    p = (i == 0) ? "sc2" : "sc1";
    chk({p, "_store"}, 32'(store_o), 32'(ex_store[i]));
    chk({p, "_busy"},  32'(busy_o),  32'(ex_busy[i]));
    chk({p, "_ack0"},  32'(ack0_o),  32'(ex_ack0[i]));
    chk({p, "_ack1"},  32'(ack1_o),  32'(ex_ack1[i]));
    chk({p, "_addr"},  32'(addr_o),  32'(ex_addr[i]));
    chk({p, "_data"},  32'(data_o),  32'(ex_data[i]));
    if (busy_o === 1'b1) chk({p, "_gid"}, 32'(gid_o), 32'(ex_gid[i]));
    if (store_o === 1'b1) ob_mem[i][addr_o] = data_o;
  endtask

  task automatic tick(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk_inst(0, a_ack0, a_ack1, a_store, a_busy, a_gid, a_addr, a_data);
      chk_inst(1, b_ack0, b_ack1, b_store, b_busy, b_gid, b_addr, b_data);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 4; a++)
        chk($sformatf("%s_mem%0d_%0d", tag, i, a),
            32'(ob_mem[i][a]), 32'(ex_mem[i][a]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 4; a++) begin
        ex_mem[i][a] = 8'h00;
        ob_mem[i][a] = 8'h00;
      end
    reset = 1'b1;
    req0 = 0; req1 = 0;
    addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    tick(2);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_store", 32'(a_store), 32'h0);
    reset = 1'b0;

    // Single write from requester 0
    req0 = 1; addr0 = 2'd2; data0 = 8'hA5;
    tick();
    req0 = 0;
    tick(8);
    chk("t1_word", 32'(ob_mem[0][2]), 32'hA5);
    chk_mem("t1");

    // Both held: alternating service starting with requester 0
    do_reset();
    req0 = 1; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1; addr1 = 2'd3; data1 = 8'h33;
    tick(26);
    req0 = 0; req1 = 0;
    tick(8);
    chk_mem("t2");

    // Requester 1 alone, then a tie goes to requester 0
    do_reset();
    req1 = 1; addr1 = 2'd1; data1 = 8'h7E;
    tick();
    req1 = 0;
    tick(7);
    req0 = 1; addr0 = 2'd2; data0 = 8'h5A;
    req1 = 1; addr1 = 2'd3; data1 = 8'hC3;
    tick();
    chk("t3_tie_gid", 32'(a_gid), 32'h0);
    req0 = 0; req1 = 0;
    tick(8);
    chk("t3_word", 32'(ob_mem[0][1]), 32'h7E);
    chk_mem("t3");

    // Operand change and request drop while busy are ignored
    do_reset();
    req0 = 1; addr0 = 2'd0; data0 = 8'h3C;
    tick(3);
    req0 = 0; data0 = 8'hFF;
    tick(8);
    chk("t4_word", 32'(ob_mem[0][0]), 32'h3C);
    chk_mem("t4");

    // Reset in the second store cycle, then a clean restart
    do_reset();
    req0 = 1; addr0 = 2'd3; data0 = 8'h96;
    tick();
    req0 = 0;
    tick(2);
    reset = 1'b1;
    tick();
    chk("t5_store", 32'(a_store), 32'h0);
    chk("t5_busy", 32'(a_busy), 32'h0);
    reset = 1'b0;
    req1 = 1; addr1 = 2'd2; data1 = 8'h42;
    tick();
    req1 = 0;
    tick(8);
    chk_mem("t5");

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      addr0 = 2'($urandom_range(0, 3));
      addr1 = 2'($urandom_range(0, 3));
      data0 = 8'($urandom);
      data1 = 8'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 0; req0 = 0; req1 = 0;
    tick(8);
    chk_mem("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
Name: mem_write_arbiter

Overview:
- Two-requester write controller for the 4-word x 8-bit latch-based memory system (data / addr / store inputs).
- Shares the memory's single write port between two requesters.
- Sequences every write as setup -> store pulse -> hold, so latch-enable timing is always clean.
- Sits between user-facing write sources (switch bank, auto-fill/test pattern engine) and the memory instance in the top level.

Parameters:
- DATA_W, 8, width of a memory word.
- ADDR_W, 2, memory address width (4 words).
- STORE_CYCLES, 2, number of clock cycles mem_store is held high per write; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  write request from requester 0.
- addr0  input  ADDR_W  write address from requester 0.
- data0  input  DATA_W  write data from requester 0.
- ack0  output  1  one-cycle completion pulse to requester 0.
- req1  input  1  write request from requester 1.
- addr1  input  ADDR_W  write address from requester 1.
- data1  input  DATA_W  write data from requester 1.
- ack1  output  1  one-cycle completion pulse to requester 1.
- mem_addr  output  ADDR_W  address to memory; registered.
- mem_data  output  DATA_W  data to memory; registered.
- mem_store  output  1  latch enable to memory; registered.
- busy  output  1  high whenever the FSM is not IDLE.
- grant_id  output  1  index of the requester being served; valid while busy.

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - state = IDLE.
  - mem_store = 0, mem_addr = 0, mem_data = 0.
  - ack0 = ack1 = 0, busy = 0, grant_id = 0.
  - last_grant pointer = 1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, STORE, HOLD, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester != last_grant.
  - On grant: capture that requester's addr/data into mem_addr/mem_data, set grant_id, go to SETUP.
- SETUP (1 cycle): mem_store = 0; address and data stable.
- STORE (STORE_CYCLES cycles):
  - mem_store = 1.
  - A down-counter sized clog2(STORE_CYCLES+1) counts the cycles; exit to HOLD when it expires.
- HOLD (1 cycle): mem_store = 0; address and data still held (latch hold time).
- DONE (1 cycle):
  - ack[grant_id] = 1, the other ack = 0.
  - last_grant <= grant_id.
  - Next state IDLE.
- Latency: the edge that samples req high in IDLE is edge 0. ack is high during the cycle following edge STORE_CYCLES+3 (edge 5 at default). A full transaction occupies STORE_CYCLES+3 cycles, plus 1 IDLE cycle before the next grant.
- Throughput: IDLE is always visited between transactions. Back-to-back requests therefore complete every STORE_CYCLES+4 cycles.
- Captured operands: addr/data are captured only at grant. Changes on addrN/dataN while busy are ignored. A request dropped mid-transaction does not abort it; the write completes and ack still pulses.
- Request after ack: a requester must deassert req in the ack cycle to avoid a repeat write. If req is still high in IDLE, it is treated as a new request and arbitrated normally.
- Requests arriving while busy wait; they are not queued beyond the level of the req line.
- mem_store never rises in the same cycle that mem_addr/mem_data change.
- Reset mid-operation: mem_store is 0 from the next edge and no ack is issued. The memory word under write may hold partial content; this is acceptable.
- Outputs are glitch-free: all outputs are driven from registers.

Test Plan:
1. Reset, then req0=1 with addr0=2, data0=0xA5 for 1 cycle -> mem_addr=2 and mem_data=0xA5 from edge 1; mem_store high for exactly 2 cycles starting after edge 2; ack0 single pulse after edge 5; ack1 never high.
2. After reset, req0 and req1 rise together (addr0=0/data0=0x11, addr1=3/data1=0x33) and stay high -> requester 0 served first, then requester 1; each ack is one cycle; grant_id sequence 0,1,0,1 while both are held.
3. req1 alone written (addr1=1, data1=0x7E), then both requests together -> requester 0 granted (last_grant=1); memory readback at addr 1 = 0x7E.
4. Grant requester 0 with data0=0x3C, then change data0 to 0xFF and drop req0 during STORE -> mem_data stays 0x3C; ack0 still pulses; the stored word is 0x3C.
5. Assert reset during the second STORE cycle -> mem_store=0, busy=0, ack0=ack1=0 on the next edge; a subsequent req1 starts cleanly from IDLE.
6. STORE_CYCLES=1 build: a single request -> mem_store high for exactly 1 cycle; ack after edge 4.
